muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_signfix.sv | 42 ++++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration count.
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // op[1] selects divide, op[0] selects signed arithmetic
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the decode/register-file side and muldiv_unit.
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            hi_we;
    logic            lo_we;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: magnitude extraction on entry, negation of the
// product or quotient/remainder on exit.
module muldiv_signfix #(
    parameter int XLEN = 32
) (
    input  logic              in_signed,
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    output logic [XLEN-1:0]   a_abs,
    output logic [XLEN-1:0]   b_abs,
    output logic              sa,
    output logic              sb,
    input  logic              out_signed,
    input  logic              out_div,
    input  logic              out_sa,
    input  logic              out_sb,
    input  logic [2*XLEN-1:0] raw_res,
    output logic [2*XLEN-1:0] fixed_res
);

    // Entry: the most negative value maps onto itself, read as unsigned
    always_comb begin
        sa    = in_signed & a_in[XLEN-1];
        sb    = in_signed & b_in[XLEN-1];
        a_abs = sa ? -a_in : a_in;
        b_abs = sb ? -b_in : b_in;
    end

    // Exit: raw_res is {hi, lo}, i.e. the product or {remainder, quotient}
    always_comb begin
        fixed_res = raw_res;
        if (out_signed && out_div) begin
            fixed_res[2*XLEN-1:XLEN] = out_sa ? -raw_res[2*XLEN-1:XLEN] : raw_res[2*XLEN-1:XLEN];
            fixed_res[XLEN-1:0]      = (out_sa ^ out_sb) ? -raw_res[XLEN-1:0] : raw_res[XLEN-1:0];
        end else if (out_signed) begin
            fixed_res = (out_sa ^ out_sb) ? -raw_res : raw_res;
        end else begin
            fixed_res = raw_res;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; one bit per
// cycle over ITERATIONS cycles, then a sign-fix/writeback cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic                bzero_q, bzero_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     raw_a_q, raw_a_d;
    logic [2*XLEN:0]     acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic [XLEN-1:0]     a_abs_s, b_abs_s;
    logic                sa_s, sb_s;
    logic [2*XLEN-1:0]   fixed_s;
    logic [XLEN:0]       mul_upper_s;
    logic [2*XLEN:0]     mul_next_s, div_next_s;
    logic [XLEN:0]       rem_sh_s;
    logic [XLEN+1:0]     diff_s;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .in_signed  (op_is_signed(bus.op)),
        .a_in       (bus.operand_a),
        .b_in       (bus.operand_b),
        .a_abs      (a_abs_s),
        .b_abs      (b_abs_s),
        .sa         (sa_s),
        .sb         (sb_s),
        .out_signed (op_is_signed(op_q)),
        .out_div    (op_is_div(op_q)),
        .out_sa     (sa_q),
        .out_sb     (sb_q),
        .raw_res    (acc_q[2*XLEN-1:0]),
        .fixed_res  (fixed_s)
    );

    // One iteration step: acc holds {upper, multiplier} or {remainder, quotient}
    always_comb begin
        mul_upper_s = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next_s  = {1'b0, mul_upper_s, acc_q[XLEN-1:1]};
        rem_sh_s    = acc_q[2*XLEN-1:XLEN-1];
        diff_s      = {1'b0, rem_sh_s} - {2'b00, opnd_q};
        if (!diff_s[XLEN+1]) begin
            div_next_s = {diff_s[XLEN:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s, acc_q[XLEN-2:0], 1'b0};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = bus.start ? ST_CALC : ST_IDLE;
            ST_CALC: state_d = (cnt_q == CNT_W'(ITERATIONS - 1)) ? ST_FIX : ST_CALC;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered status and HI/LO
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        dz_d   = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                    if (bus.hi_we) hi_d = bus.operand_a;
                    else           hi_d = hi_q;
                    if (bus.lo_we) lo_d = bus.operand_a;
                    else           lo_d = lo_q;
                end
            end
            ST_CALC: busy_d = 1'b1;
            ST_FIX: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (op_is_div(op_q) && bzero_q) begin
                    dz_d = 1'b1;
                    hi_d = raw_a_q;
                    lo_d = {XLEN{1'b1}};
                end else begin
                    dz_d = 1'b0;
                    {hi_d, lo_d} = fixed_s;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath next values: operand capture, iteration, counter
    always_comb begin
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bzero_d = bzero_q;
        opnd_d  = opnd_q;
        raw_a_d = raw_a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    sa_d    = sa_s;
                    sb_d    = sb_s;
                    bzero_d = (bus.operand_b == {XLEN{1'b0}});
                    raw_a_d = bus.operand_a;
                    opnd_d  = op_is_div(bus.op) ? b_abs_s : a_abs_s;
                    acc_d   = {{(XLEN+1){1'b0}}, (op_is_div(bus.op) ? a_abs_s : b_abs_s)};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_CALC: begin
                acc_d = op_is_div(op_q) ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_FIX:  cnt_d = {CNT_W{1'b0}};
            default: cnt_d = {CNT_W{1'b0}};
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= 2'b00;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
            opnd_q  <= {XLEN{1'b0}};
            raw_a_q <= {XLEN{1'b0}};
            acc_q   <= {(2*XLEN+1){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
        end else begin
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bzero_q <= bzero_d;
            opnd_q  <= opnd_d;
            raw_a_q <= raw_a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
